// File: rtl/feature_cache_write_arbiter_pkg.sv
// Shared types and defaults for the feature-cache write-port arbiter.
// Cache geometry and the write-port struct are reused by every cache writer.
package feature_cache_write_arbiter_pkg;

    localparam int unsigned FC_ADDR_WIDTH   = 10;
    localparam int unsigned FC_WORD_SIZE    = 32;
    localparam int unsigned FCW_ARB_NUM_REQ = 2;
    localparam int unsigned FCW_ARB_TIMEOUT = 1024;
    localparam int unsigned IDLE_CNT_WIDTH  = 16;

    typedef struct packed {
        logic                     we;
        logic [FC_ADDR_WIDTH-1:0] waddr;
        logic [FC_WORD_SIZE-1:0]  wdata;
    } fc_write_t;

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } fcw_arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/feature_cache_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping.
// Shared by arbiters that multiplex a single port.
module feature_cache_write_arbiter_rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [IdxW-1:0] grant_idx,
    output logic            any
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int             first;
    int             sum;

    always_comb begin
        // Rotate so that bit 0 corresponds to ptr; the lowest set bit is the winner.
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        any     = |req;
        first   = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_rot[i]) first = i;
        end
        sum = int'(ptr) + first;
        if (sum >= int'(N)) sum = sum - int'(N);
        grant_idx = IdxW'(sum);
    end

endmodule

// File: rtl/feature_cache_write_arbiter.sv
// Round-robin burst arbiter for the shared feature-cache write port, with a
// stall watchdog and a registered write output.
module feature_cache_write_arbiter
    import feature_cache_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = FCW_ARB_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = FC_ADDR_WIDTH,
    parameter int unsigned WORD_SIZE  = FC_WORD_SIZE,
    parameter int unsigned TIMEOUT    = FCW_ARB_TIMEOUT,
    localparam int unsigned IdxW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output fc_write_t                     fcw,
    output logic                          busy,
    output logic                          burst_done,
    output logic                          timeout_err,
    output logic [IdxW-1:0]               done_id
);

    fcw_arb_state_e            state_q, state_d;
    logic [IdxW-1:0]           grant_q, grant_d;
    logic [IdxW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IDLE_CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
    logic [IDLE_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    fc_write_t                 fcw_q, fcw_d;
    logic                      burst_done_q, burst_done_d;
    logic                      timeout_err_q, timeout_err_d;
    logic [IdxW-1:0]           done_id_q, done_id_d;

    logic [IdxW-1:0]       pick_idx;
    logic                  pick_any;
    logic [IdxW-1:0]       ptr_inc;
    logic                  cur_valid;
    logic                  cur_last;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [WORD_SIZE-1:0]  cur_data;
    logic                  timeout_hit;

    feature_cache_write_arbiter_rr_pick #(
        .N(NUM_REQ)
    ) u_rr_pick (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant_idx(pick_idx),
        .any      (pick_any)
    );

    assign cur_valid   = req_valid[grant_q];
    assign cur_last    = req_last[grant_q];
    assign cur_addr    = req_addr[32'(grant_q) * ADDR_WIDTH +: ADDR_WIDTH];
    assign cur_data    = req_data[32'(grant_q) * WORD_SIZE +: WORD_SIZE];
    assign ptr_inc     = IdxW'(wrap_inc(32'(grant_q), NUM_REQ));
    // A zero TIMEOUT disables the watchdog entirely.
    assign timeout_hit = (TIMEOUT != 0) && (idle_cnt_q == IDLE_CNT_WIDTH'(TIMEOUT - 1));

    always_comb begin
        req_ready = '0;
        if (state_q == StBurst) req_ready[grant_q] = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        fcw_d         = fcw_q;
        fcw_d.we      = 1'b0;
        burst_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        done_id_d     = done_id_q;

        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    idle_cnt_d = '0;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                if (cur_valid) begin
                    fcw_d.we    = 1'b1;
                    fcw_d.waddr = cur_addr;
                    fcw_d.wdata = cur_data;
                    idle_cnt_d  = '0;
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
                    if (cur_last) begin
                        state_d      = StIdle;
                        rr_ptr_d     = ptr_inc;
                        burst_done_d = 1'b1;
                        done_id_d    = grant_q;
                    end
                end else if (timeout_hit) begin
                    state_d       = StIdle;
                    rr_ptr_d      = ptr_inc;
                    timeout_err_d = 1'b1;
                    done_id_d     = grant_q;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            idle_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            fcw_q         <= '0;
            burst_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            done_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            fcw_q         <= fcw_d;
            burst_done_q  <= burst_done_d;
            timeout_err_q <= timeout_err_d;
            done_id_q     <= done_id_d;
        end
    end

    assign fcw         = fcw_q;
    assign busy        = (state_q == StBurst);
    assign burst_done  = burst_done_q;
    assign timeout_err = timeout_err_q;
    assign done_id     = done_id_q;

endmodule

// File: tb/tb_feature_cache_write_arbiter.sv
// Directed bench for feature_cache_write_arbiter: vector table for bursts and
// arbitration order, hand sequences for watchdog, valid gaps and mid-burst reset.
module tb_feature_cache_write_arbiter;
    import feature_cache_write_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_last;
    logic [19:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    fc_write_t   fcw;
    logic        busy;
    logic        burst_done;
    logic        timeout_err;
    logic        done_id;

    int errors = 0;
    int checks = 0;

    feature_cache_write_arbiter #(
        .NUM_REQ(2),
        .TIMEOUT(8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fcw        (fcw),
        .busy       (busy),
        .burst_done (burst_done),
        .timeout_err(timeout_err),
        .done_id    (done_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [1:0]  last;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic [1:0]  e_ready;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_done;
        logic        e_id;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic [1:0] v, input logic [1:0] l,
                       input logic [9:0] a0, input logic [31:0] d0,
                       input logic [9:0] a1, input logic [31:0] d1);
        reset     = rst;
        req_valid = v;
        req_last  = l;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        @(posedge clk);
        #1;
    endtask

    function automatic void row(input logic rst, input logic [1:0] v, input logic [1:0] l,
                                input logic [9:0] a0, input logic [31:0] d0,
                                input logic [9:0] a1, input logic [31:0] d1,
                                input logic [1:0] e_ready, input logic e_we,
                                input logic [9:0] e_addr, input logic [31:0] e_data,
                                input logic e_busy, input logic e_done, input logic e_id);
        vec_t x;
        x.rst = rst; x.valid = v; x.last = l;
        x.a0 = a0; x.d0 = d0; x.a1 = a1; x.d1 = d1;
        x.e_ready = e_ready; x.e_we = e_we; x.e_addr = e_addr; x.e_data = e_data;
        x.e_busy = e_busy; x.e_done = e_done; x.e_id = e_id;
        vecs.push_back(x);
    endfunction

    function automatic logic [9:0] ca(input int r, input int b);
        return 10'((r == 0) ? 'h10 + b : 'h20 + b);
    endfunction

    function automatic logic [31:0] cd(input int r, input int b);
        return 32'((r == 0) ? 'hB0 + b : 'hC0 + b);
    endfunction

    // One contention row: requester f presents beat bf, the other presents beat bs.
    function automatic void crow(input int f, input logic [1:0] v, input logic [1:0] l,
                                 input int bf, input int bs, input logic [1:0] e_ready,
                                 input logic e_we, input int e_r, input int e_b,
                                 input logic e_busy, input logic e_done);
        int b0 = (f == 0) ? bf : bs;
        int b1 = (f == 1) ? bf : bs;
        row(1'b0, v, l, ca(0, b0), cd(0, b0), ca(1, b1), cd(1, b1),
            e_ready, e_we, ca(e_r, e_b), cd(e_r, e_b), e_busy, e_done, e_r[0]);
    endfunction

    // Both requesters raise a 3-beat burst together; f is expected to win first.
    function automatic void add_cont(input int f);
        int         s  = 1 - f;
        logic [1:0] fm = 2'(1 << f);
        logic [1:0] sm = 2'(1 << s);
        crow(f, 2'b11, 2'b00, 0, 0, fm,    1'b0, f, 0, 1'b1, 1'b0);
        crow(f, 2'b11, 2'b00, 0, 0, fm,    1'b1, f, 0, 1'b1, 1'b0);
        crow(f, 2'b11, 2'b00, 1, 0, fm,    1'b1, f, 1, 1'b1, 1'b0);
        crow(f, 2'b11, fm,    2, 0, 2'b00, 1'b1, f, 2, 1'b0, 1'b1);
        crow(f, sm,    2'b00, 0, 0, sm,    1'b0, s, 0, 1'b1, 1'b0);
        crow(f, sm,    2'b00, 0, 0, sm,    1'b1, s, 0, 1'b1, 1'b0);
        crow(f, sm,    2'b00, 0, 1, sm,    1'b1, s, 1, 1'b1, 1'b0);
        crow(f, sm,    sm,    0, 2, 2'b00, 1'b1, s, 2, 1'b0, 1'b1);
        crow(f, 2'b00, 2'b00, 0, 0, 2'b00, 1'b0, s, 0, 1'b0, 1'b0);
    endfunction

    initial begin
        int nw;
        int nerr;

        reset = 1'b1; req_valid = '0; req_last = '0; req_addr = '0; req_data = '0;

        // Reset, then a single 4-beat burst from req0 (leaves rr_ptr at 1).
        row(1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        row(1'b0, 2'b01, 2'b00, 0, 'hA0, 0, 0, 2'b01, 1'b0, 0, 0,     1'b1, 1'b0, 1'b0);
        row(1'b0, 2'b01, 2'b00, 0, 'hA0, 0, 0, 2'b01, 1'b1, 0, 'hA0,  1'b1, 1'b0, 1'b0);
        row(1'b0, 2'b01, 2'b00, 1, 'hA1, 0, 0, 2'b01, 1'b1, 1, 'hA1,  1'b1, 1'b0, 1'b0);
        row(1'b0, 2'b01, 2'b00, 2, 'hA2, 0, 0, 2'b01, 1'b1, 2, 'hA2,  1'b1, 1'b0, 1'b0);
        row(1'b0, 2'b01, 2'b01, 3, 'hA3, 0, 0, 2'b00, 1'b1, 3, 'hA3,  1'b0, 1'b1, 1'b0);
        row(1'b0, 2'b00, 2'b00, 0, 0,    0, 0, 2'b00, 1'b0, 0, 0,     1'b0, 1'b0, 1'b0);
        // rr_ptr=1: req1 wins the tie, then req0 (rr_ptr back to 1).
        add_cont(1);
        // From reset: req0 first, then req1 leaves rr_ptr=0, so the repeat starts at req0.
        row(1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        add_cont(0);
        add_cont(0);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].valid, vecs[i].last,
                vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            check($sformatf("v%0d.ready", i), 64'(req_ready),   64'(vecs[i].e_ready));
            check($sformatf("v%0d.we", i),    64'(fcw.we),      64'(vecs[i].e_we));
            check($sformatf("v%0d.busy", i),  64'(busy),        64'(vecs[i].e_busy));
            check($sformatf("v%0d.done", i),  64'(burst_done),  64'(vecs[i].e_done));
            check($sformatf("v%0d.terr", i),  64'(timeout_err), 64'(0));
            if (vecs[i].e_we || vecs[i].rst) begin
                check($sformatf("v%0d.addr", i), 64'(fcw.waddr), 64'(vecs[i].e_addr));
                check($sformatf("v%0d.data", i), 64'(fcw.wdata), 64'(vecs[i].e_data));
            end
            if (vecs[i].e_done || vecs[i].rst)
                check($sformatf("v%0d.id", i), 64'(done_id), 64'(vecs[i].e_id));
        end

        // Watchdog: req1 sends 2 beats then stalls while req0 waits (rr_ptr=0 here).
        cyc(1'b0, 2'b10, 2'b00, 0, 0, 'h30, 'hD0);
        check("to.grant1", 64'(req_ready), 64'(2'b10));
        cyc(1'b0, 2'b10, 2'b00, 0, 0, 'h30, 'hD0);
        check("to.wr0", 64'({fcw.we, fcw.waddr}), 64'({1'b1, 10'h30}));
        cyc(1'b0, 2'b11, 2'b00, 'h60, 'hE0, 'h31, 'hD1);
        check("to.wr1", 64'({fcw.we, fcw.waddr}), 64'({1'b1, 10'h31}));
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 2'b01, 2'b00, 'h60, 'hE0, 0, 0);
            check($sformatf("to.idle%0d.we", k), 64'(fcw.we), 64'(0));
            if (k < 7) begin
                check($sformatf("to.idle%0d.terr", k),  64'(timeout_err), 64'(0));
                check($sformatf("to.idle%0d.ready", k), 64'(req_ready),   64'(2'b10));
            end else begin
                check("to.terr",  64'(timeout_err), 64'(1));
                check("to.id",    64'(done_id),     64'(1));
                check("to.busy",  64'(busy),        64'(0));
                check("to.done",  64'(burst_done),  64'(0));
            end
        end
        cyc(1'b0, 2'b01, 2'b01, 'h60, 'hE0, 0, 0);
        check("to.grant0", 64'(req_ready), 64'(2'b01));
        check("to.terr1c", 64'(timeout_err), 64'(0));
        check("to.nowr",   64'(fcw.we), 64'(0));
        cyc(1'b0, 2'b01, 2'b01, 'h60, 'hE0, 0, 0);
        check("to.r0wr", 64'({fcw.we, fcw.waddr, fcw.wdata}), 64'({1'b1, 10'h60, 32'hE0}));
        check("to.r0done", 64'({burst_done, done_id}), 64'(2'b10));
        cyc(1'b0, 2'b00, 2'b00, 0, 0, 0, 0);

        // Valid gap of 3 cycles inside a req0 burst: grant held, 3 writes, no error.
        nw = 0;
        nerr = 0;
        cyc(1'b0, 2'b01, 2'b00, 'h40, 'hF0, 0, 0);
        check("gap.grant", 64'(req_ready), 64'(2'b01));
        cyc(1'b0, 2'b01, 2'b00, 'h40, 'hF0, 0, 0);
        nw += int'(fcw.we); nerr += int'(timeout_err);
        check("gap.wr0", 64'(fcw.waddr), 64'(10'h40));
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 2'b00, 2'b00, 0, 0, 0, 0);
            nw += int'(fcw.we); nerr += int'(timeout_err);
            check($sformatf("gap.hold%0d", k), 64'({busy, req_ready}), 64'(3'b101));
        end
        cyc(1'b0, 2'b01, 2'b00, 'h41, 'hF1, 0, 0);
        nw += int'(fcw.we); nerr += int'(timeout_err);
        check("gap.wr1", 64'(fcw.waddr), 64'(10'h41));
        cyc(1'b0, 2'b01, 2'b01, 'h42, 'hF2, 0, 0);
        nw += int'(fcw.we); nerr += int'(timeout_err);
        check("gap.wr2", 64'({fcw.waddr, fcw.wdata}), 64'({10'h42, 32'hF2}));
        check("gap.done", 64'({burst_done, done_id}), 64'(2'b10));
        cyc(1'b0, 2'b00, 2'b00, 0, 0, 0, 0);
        nw += int'(fcw.we); nerr += int'(timeout_err);
        check("gap.nwrites", 64'(nw), 64'(3));
        check("gap.nerr", 64'(nerr), 64'(0));

        // Reset during beat 2 of 5 (rr_ptr=1 beforehand); re-arbitration must start at req0.
        cyc(1'b0, 2'b01, 2'b00, 'h50, 'h90, 0, 0);
        check("rst.grant", 64'(req_ready), 64'(2'b01));
        cyc(1'b0, 2'b01, 2'b00, 'h50, 'h90, 0, 0);
        check("rst.wr0", 64'({fcw.we, fcw.waddr}), 64'({1'b1, 10'h50}));
        cyc(1'b1, 2'b01, 2'b00, 'h51, 'h91, 0, 0);
        check("rst.fcw",   64'(fcw),         64'(0));
        check("rst.ready", 64'(req_ready),   64'(0));
        check("rst.busy",  64'(busy),        64'(0));
        check("rst.pulse", 64'({burst_done, timeout_err, done_id}), 64'(0));
        cyc(1'b0, 2'b11, 2'b00, 'h50, 'h90, 'h70, 'h71);
        check("rst.regrant", 64'(req_ready), 64'(2'b01));
        check("rst.nodone",  64'({burst_done, fcw.we}), 64'(0));
        cyc(1'b0, 2'b11, 2'b01, 'h50, 'h90, 'h70, 'h71);
        check("rst.r0wr", 64'({fcw.we, fcw.waddr, burst_done, done_id}),
              64'({1'b1, 10'h50, 1'b1, 1'b0}));
        cyc(1'b0, 2'b10, 2'b00, 0, 0, 'h70, 'h71);
        check("rst.grant1", 64'(req_ready), 64'(2'b10));
        cyc(1'b0, 2'b10, 2'b10, 0, 0, 'h70, 'h71);
        check("rst.r1wr", 64'({fcw.we, fcw.wdata, burst_done, done_id}),
              64'({1'b1, 32'h71, 1'b1, 1'b1}));
        cyc(1'b0, 2'b00, 2'b00, 0, 0, 0, 0);
        check("rst.end", 64'({fcw.we, busy, burst_done}), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
